imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Synthesizable program loader: receives a byte stream from a host link over a valid/ready
//  handshake and writes 32-bit little-endian words into instruction memory from word 0.
//  Holds the CPU core in reset while loading and releases it when the image is complete.
//  Sits between the host link and the imem write port; the CPU only reads imem.
// PARAMETERS
//  ADDR_WIDTH  8   imem word-address width; capacity = 2**ADDR_WIDTH words
// PORTS
//  clk         in   1           system clock, rising edge
//  rstn        in   1           asynchronous, active-low reset
//  reload      in   1           1-cycle pulse: restart loading, hold CPU in reset
//  rx_valid    in   1           host byte valid
//  rx_data     in   8           host byte
//  rx_ready    out  1           loader accepts byte (transfer = rx_valid & rx_ready)
//  imem_we     out  1           imem write strobe, 1 cycle per word
//  imem_addr   out  ADDR_WIDTH  imem word address
//  imem_wdata  out  32          imem write data
//  cpu_rstn    out  1           CPU reset, active-low; 1 only in RUN
//  done        out  1           image loaded, CPU running
//  error       out  1           load failed; sticky until reload or rstn
// BEHAVIOUR
//  - Frame: LEN_LO, LEN_HI (N = 16-bit word count, LE), then 4*N data bytes, byte 0 = bits [7:0].
//  - States: LEN_LO -> LEN_HI -> DATA -> RUN; ERR. All outputs are registered.
//  - Reset (rstn low, async): state=LEN_LO, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//    cpu_rstn=0, done=0, error=0, byte/word counters=0. rx_ready rises on the first clk after release.
//  - rx_ready=1 in LEN_LO, LEN_HI, DATA (and CSUM); 0 in RUN and ERR. No byte is dropped.
//  - LEN_HI accept: N==0 -> RUN (or CSUM); N > 2**ADDR_WIDTH -> ERR; otherwise -> DATA.
//  - DATA: bytes are shifted into the word register; on the 4th byte, the next cycle gives
//    imem_we=1, imem_addr=word index (0..N-1), imem_wdata=assembled word. Back-to-back
//    bytes are sustained at 1 byte/cycle.
//  - After word N-1 is accepted, go to RUN (or CSUM). imem_we for the last word is issued
//    in the same cycle that the state becomes RUN. cpu_rstn and done rise 1 cycle later, so
//    the write is complete before the CPU leaves reset.
//  - RUN: cpu_rstn=1, done=1. Host bytes are not accepted.
//  - ERR: error=1, cpu_rstn=0, done=0. Only reload or rstn exits.
//  - reload (any state, sampled on clk): next state=LEN_LO and counters=0.
//    cpu_rstn, done, error and imem_we are 0 next cycle. reload has priority over a
//    simultaneous byte transfer, and that byte is discarded.
//    Reload mid-DATA abandons the partial word (no write). Already-written words are left intact.
//  - Word index is ADDR_WIDTH+1 bits wide internally, so N = 2**ADDR_WIDTH is legal
//    and imem_addr does not wrap.
// CONFIGURATION
//  IMEM_LOADER_CSUM_EN defined: after the data bytes (or after LEN_HI when N==0), state CSUM
//    accepts 1 byte. If it equals the XOR of all data bytes (0x00 for N==0), go to RUN;
//    otherwise go to ERR. The running XOR is reset on reload.
//  IMEM_LOADER_CSUM_EN undefined: no CSUM state; the frame ends after the data bytes.
// TESTING
//  1. rstn low, N=2, data 13 05 00 00 93 00 10 00 back-to-back -> imem_we at addr 0 = 0x00000513,
//     addr 1 = 0x00100093. cpu_rstn=1 and done=1 exactly 1 cycle after the last write.
//  2. N=0 (00 00) -> no imem_we; RUN within 1 cycle of the LEN_HI accept (CSUM_EN: after csum 00).
//  3. ADDR_WIDTH=8, N=0x0101 -> error=1, rx_ready=0, cpu_rstn stays 0. Reload -> error=0, rx_ready=1.
//  4. rx_valid toggled randomly with gaps, N=3 -> identical writes to the gapless case. Bytes held
//     while rx_ready=0 in RUN are never consumed.
//  5. Reload asserted in the same cycle as the 2nd byte of word 1 -> no write to addr 1.
//     A fresh N=1 frame then writes addr 0 and enters RUN.
//  6. CSUM_EN, N=1, data 01 02 04 08: csum 0F -> RUN; csum 0E -> ERR, cpu_rstn=0.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing LE words into imem, gating CPU reset
// Optional trailing XOR checksum byte when IMEM_LOADER_CSUM_EN is defined.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  reload,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rstn,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

`ifdef IMEM_LOADER_CSUM_EN
   localparam state_t S_FRAME_END = S_CSUM;
`else
   localparam state_t S_FRAME_END = S_RUN;
`endif
   localparam int unsigned CAP = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [7:0]            len_lo_q, len_lo_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
   logic [23:0]           shift_q, shift_d;
   logic                  rx_ready_q, rx_ready_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  cpu_rstn_q, cpu_rstn_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif

   logic                  xfer;
   logic [15:0]           n_len;
   logic [ADDR_WIDTH:0]   word_next;

   assign xfer      = rx_valid & rx_ready_q;
   assign n_len     = {rx_data, len_lo_q};
   assign word_next = word_idx_q + IDX_ONE;

   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      len_d        = len_q;
      byte_cnt_d   = byte_cnt_q;
      word_idx_d   = word_idx_q;
      shift_d      = shift_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d       = csum_q;
`endif
      // reload wins over any byte presented in the same cycle; that byte is dropped
      if (reload) begin
         state_d    = S_LEN_LO;
         byte_cnt_d = 2'd0;
         word_idx_d = '0;
         shift_d    = 24'd0;
`ifdef IMEM_LOADER_CSUM_EN
         csum_d     = 8'd0;
`endif
      end else if (xfer) begin
         case (state_q)
            S_LEN_LO: begin
               len_lo_d = rx_data;
               state_d  = S_LEN_HI;
            end
            S_LEN_HI: begin
               if (n_len == 16'd0) begin
                  state_d = S_FRAME_END;
               end else if ({16'd0, n_len} > CAP) begin
                  state_d = S_ERR;
               end else begin
                  len_d   = n_len[ADDR_WIDTH:0];
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                  imem_wdata_d = {rx_data, shift_q};
                  word_idx_d   = word_next;
                  if (word_next == len_q) state_d = S_FRAME_END;
               end else begin
                  shift_d = {rx_data, shift_q[23:8]};
               end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
`endif
            default: ;
         endcase
      end
      rx_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                   (state_d == S_DATA)   || (state_d == S_CSUM);
      // one cycle behind RUN so the final imem write lands before the core starts
      cpu_rstn_d = (state_q == S_RUN) && !reload;
      done_d     = (state_q == S_RUN) && !reload;
      error_d    = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_LEN_LO;
         len_lo_q     <= 8'd0;
         len_q        <= '0;
         byte_cnt_q   <= 2'd0;
         word_idx_q   <= '0;
         shift_q      <= 24'd0;
         rx_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'd0;
         cpu_rstn_q   <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q       <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         byte_cnt_q   <= byte_cnt_d;
         word_idx_q   <= word_idx_d;
         shift_q      <= shift_d;
         rx_ready_q   <= rx_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_rstn_q   <= cpu_rstn_d;
         done_q       <= done_d;
         error_q      <= error_d;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_rstn   = cpu_rstn_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (frame-level model + directed vectors)
module tb_imem_loader;

   localparam int AW  = 8;
   localparam int CAP = 1 << AW;
   localparam int OUT_NONE = 0;
   localparam int OUT_RUN  = 1;
   localparam int OUT_ERR  = 2;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          reload = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rstn;
   logic          done;
   logic          error;

   int            n_checks = 0;
   int            n_fail = 0;
   int            n_wr = 0;
   wr_t           exp_q[$];
   logic [31:0]   seen [0:CAP-1];

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn), .reload(reload), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_rstn(cpu_rstn), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Frame-level model: parse length, collect completed words, decide the outcome.
   task automatic model(input bq_t fr, input int nb, output int outc);
      int n;
      logic [7:0] x;
      wr_t e;
      outc = OUT_NONE;
      if (nb < 2) return;
      n = int'(fr[0]) | (int'(fr[1]) << 8);
      if (n > CAP) begin
         outc = OUT_ERR;
         return;
      end
      x = 8'd0;
      for (int w = 0; w < n; w++) begin
         if (2 + 4*w + 3 < nb) begin
            e.addr = AW'(w);
            e.data = {fr[5+4*w], fr[4+4*w], fr[3+4*w], fr[2+4*w]};
            exp_q.push_back(e);
         end
      end
      for (int i = 2; i < 2 + 4*n && i < nb; i++) x = x ^ fr[i];
`ifdef IMEM_LOADER_CSUM_EN
      if (nb > 2 + 4*n) outc = (fr[2+4*n] == x) ? OUT_RUN : OUT_ERR;
`else
      if (nb >= 2 + 4*n) outc = OUT_RUN;
`endif
   endtask

   function automatic logic [7:0] xor_of(input bq_t fr);
      logic [7:0] x = 8'd0;
      for (int i = 2; i < fr.size(); i++) x = x ^ fr[i];
      return x;
   endfunction

   always @(negedge clk) begin
      if (rstn) begin
         check("cpu_rstn_eq_done", {31'd0, cpu_rstn}, {31'd0, done});
         if (error) check("err_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
         if (error || done) check("ready_low_run_err", {31'd0, rx_ready}, 32'd0);
      end
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                     imem_addr, imem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", {24'd0, imem_addr}, {24'd0, e.addr});
            check("wr_data", imem_wdata, e.data);
         end
         seen[imem_addr] = imem_wdata;
         n_wr++;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      bit r;
      rx_valid = 1'b1;
      rx_data  = b;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         r = rx_ready;
         @(posedge clk);
         #1;
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL rx_ready_timeout: got rx_ready 0 for 100 cycles, expected 1");
      end
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      check("reload_we", {31'd0, imem_we}, 32'd0);
      check("reload_done", {31'd0, done}, 32'd0);
      check("reload_error", {31'd0, error}, 32'd0);
      check("reload_ready", {31'd0, rx_ready}, 32'd1);
   endtask

   task automatic send_frame(input bq_t fr, input int max_gap, input string tag);
      int outc;
      int n;
      int k;
      int g;
      model(fr, fr.size(), outc);
      n = int'(fr[0]) | (int'(fr[1]) << 8);
      for (int i = 0; i < fr.size(); i++) begin
         if (max_gap > 0) begin
            g = $urandom_range(0, max_gap);
            if (g > 0) begin
               rx_valid = 1'b0;
               repeat (g) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
         send_byte(fr[i]);
      end
      rx_valid = 1'b0;
`ifndef IMEM_LOADER_CSUM_EN
      if (outc == OUT_RUN && n > 0) begin
         check({tag, "_last_we"}, {31'd0, imem_we}, 32'd1);
         check({tag, "_last_addr"}, {24'd0, imem_addr}, 32'(n - 1));
      end
`endif
      if (outc == OUT_RUN) begin
         for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
         end
         check({tag, "_run_latency"}, 32'(k), 32'd1);
         check({tag, "_cpu_rstn"}, {31'd0, cpu_rstn}, 32'd1);
      end else if (outc == OUT_ERR) begin
         for (k = 0; k <= 20; k++) begin
            if (error) break;
            @(posedge clk);
            #1;
         end
         check({tag, "_error"}, {31'd0, error}, 32'd1);
         check({tag, "_err_ready"}, {31'd0, rx_ready}, 32'd0);
         check({tag, "_err_cpu_rstn"}, {31'd0, cpu_rstn}, 32'd0);
      end
      check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bq_t fr;
      int outc;
      int base;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("rst_imem_we", {31'd0, imem_we}, 32'd0);
      check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_release", {31'd0, rx_ready}, 32'd1);

      // 1: two-word image, back-to-back
      fr = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
      fr.push_back(xor_of(fr));
`endif
      send_frame(fr, 0, "t1");
      check("t1_word0", seen[0], 32'h00000513);
      check("t1_word1", seen[1], 32'h00100093);

      // 2: empty image
      do_reload();
      base = n_wr;
      fr = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
      fr.push_back(8'h00);
`endif
      send_frame(fr, 0, "t2");
      check("t2_no_write", 32'(n_wr - base), 32'd0);

      // 3: length one past capacity
      do_reload();
      fr = '{8'h01, 8'h01};
      send_frame(fr, 0, "t3");
      repeat (5) begin
         @(negedge clk);
         check("t3_cpu_held", {31'd0, cpu_rstn}, 32'd0);
      end
      do_reload();

      // 4: three words with random gaps, then bytes held against RUN
      fr = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
             8'h01, 8'h00, 8'hFF, 8'h80};
`ifdef IMEM_LOADER_CSUM_EN
      fr.push_back(xor_of(fr));
`endif
      send_frame(fr, 3, "t4");
      check("t4_word0", seen[0], 32'hDEADBEEF);
      check("t4_word2", seen[2], 32'h80FF0001);
      base = n_wr;
      rx_valid = 1'b1;
      rx_data  = 8'hEE;
      repeat (8) begin
         @(negedge clk);
         check("t4_run_ready", {31'd0, rx_ready}, 32'd0);
      end
      rx_valid = 1'b0;
      check("t4_run_no_write", 32'(n_wr - base), 32'd0);

      // 5: reload on the 2nd byte of word 1
      do_reload();
      fr = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      model(fr, fr.size(), outc);
      base = n_wr;
      for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
      rx_valid = 1'b1;
      rx_data  = 8'h66;
      reload   = 1'b1;
      @(posedge clk);
      #1;
      reload   = 1'b0;
      rx_valid = 1'b0;
      check("t5_reload_we", {31'd0, imem_we}, 32'd0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("t5_one_write", 32'(n_wr - base), 32'd1);
      check("t5_word0", seen[0], 32'h44332211);
      fr = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CSUM_EN
      fr.push_back(xor_of(fr));
`endif
      send_frame(fr, 0, "t5b");
      check("t5b_word0", seen[0], 32'hDDCCBBAA);

`ifdef IMEM_LOADER_CSUM_EN
      // 6: checksum good and bad
      do_reload();
      fr = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
      send_frame(fr, 0, "t6_good");
      check("t6_word0", seen[0], 32'h08040201);
      do_reload();
      fr = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
      send_frame(fr, 0, "t6_bad");
      do_reload();
`endif

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
